// File: rtl/led_fade_driver.sv
// Four-channel LED driver with PWM fade-in/fade-out between on and off requests.
// Fading is built only when LED_FADE_EN is defined; otherwise the LEDs follow led_export after two registers.
module led_fade_driver #(
  parameter int PWM_BITS        = 8,
  parameter int PRESCALE        = 196,
  parameter int FADE_STEP_TICKS = 4,
  parameter int MAX_DUTY        = 255
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [3:0] led_export,
  output logic [3:0] led_out,
  output logic       busy
);

  if (PWM_BITS < 1 || PRESCALE < 1 || PRESCALE > 65535 ||
      FADE_STEP_TICKS < 1 || FADE_STEP_TICKS > 255 ||
      MAX_DUTY < 1 || MAX_DUTY > (2 ** PWM_BITS) - 1) begin : g_bad_cfg
    $error("led_fade_driver: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } chan_state_t;

  logic [3:0]  led_q;
  chan_state_t state      [4];
  chan_state_t state_next [4];

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      led_q <= '0;
    end else begin
      led_q <= led_export;
    end
  end

`ifdef LED_FADE_EN

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SC_W = (FADE_STEP_TICKS > 1) ? $clog2(FADE_STEP_TICKS) : 1;
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [SC_W-1:0]     SC_LAST = SC_W'(FADE_STEP_TICKS - 1);
  localparam logic [PWM_BITS-1:0] MAX_D   = PWM_BITS'(MAX_DUTY);
  localparam logic [PWM_BITS-1:0] ONE_D   = PWM_BITS'(1);

  logic [PS_W-1:0]     presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [SC_W-1:0]     step_cnt;
  logic                tick;
  logic                period_end;
  logic                step;
  logic [PWM_BITS-1:0] duty      [4];
  logic [PWM_BITS-1:0] duty_next [4];
  logic [3:0]          fading;

  assign tick       = (presc == PS_LAST);
  assign period_end = tick && (pwm_cnt == '1);
  assign step       = period_end && (step_cnt == SC_LAST);

  // Timebase shared by all channels keeps their fades phase-aligned.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      presc    <= '0;
      pwm_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + PS_W'(1);
      if (tick) begin
        pwm_cnt <= pwm_cnt + ONE_D;
      end
      if (period_end) begin
        step_cnt <= step ? '0 : step_cnt + SC_W'(1);
      end
    end
  end

  // Direction is resolved first so a step in the same cycle follows the new direction.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      state_next[i] = state[i];
      duty_next[i]  = duty[i];
      case (state[i])
        ST_OFF:       if (led_q[i])  state_next[i] = ST_RAMP_UP;
        ST_RAMP_UP:   if (!led_q[i]) state_next[i] = ST_RAMP_DOWN;
        ST_ON:        if (!led_q[i]) state_next[i] = ST_RAMP_DOWN;
        ST_RAMP_DOWN: if (led_q[i])  state_next[i] = ST_RAMP_UP;
        default:      state_next[i] = ST_OFF;
      endcase
      if (step && state_next[i] == ST_RAMP_UP) begin
        if (duty[i] >= MAX_D - ONE_D) begin
          duty_next[i]  = MAX_D;
          state_next[i] = ST_ON;
        end else begin
          duty_next[i] = duty[i] + ONE_D;
        end
      end else if (step && state_next[i] == ST_RAMP_DOWN) begin
        if (duty[i] <= ONE_D) begin
          duty_next[i]  = '0;
          state_next[i] = ST_OFF;
        end else begin
          duty_next[i] = duty[i] - ONE_D;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      fading[i] = (state[i] == ST_RAMP_UP) || (state[i] == ST_RAMP_DOWN);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state   <= '{default: ST_OFF};
      duty    <= '{default: '0};
      led_out <= '0;
      busy    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        state[i] <= state_next[i];
        duty[i]  <= duty_next[i];
        case (state[i])
          ST_ON:   led_out[i] <= 1'b1;
          ST_OFF:  led_out[i] <= 1'b0;
          default: led_out[i] <= (pwm_cnt < duty[i]);
        endcase
      end
      busy <= |fading;
    end
  end

`else

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      state_next[i] = state[i];
      case (state[i])
        ST_OFF:  if (led_q[i])  state_next[i] = ST_ON;
        default: if (!led_q[i]) state_next[i] = ST_OFF;
      endcase
    end
  end

  // Output is registered from the next state, so it lands one cycle after led_q.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state   <= '{default: ST_OFF};
      led_out <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        state[i]   <= state_next[i];
        led_out[i] <= (state_next[i] == ST_ON);
      end
    end
  end

  assign busy = 1'b0;

`endif

endmodule
